// File: rtl/sum_pkg.sv
// Shared definitions for the N-operand summer and its operand loader:
// default frame geometry, count-width helper and loader state encoding.
package sum_pkg;

   localparam int SUM_N = 20;
   localparam int SUM_W = 5;

   // Width needed to hold an operand count in the range 0..n.
   function automatic int cnt_width(input int n);
      return $clog2(n + 1);
   endfunction

   typedef enum logic {
      FILL = 1'b0,
      BUSY = 1'b1
   } loader_state_e;

endpackage

// File: rtl/sum_operand_loader_if.sv
// Stream-in / parallel-out bus between the operand source, the loader and
// the summer. The loader sits on the slave modport; the source/summer side
// (or a bench) drives through the master modport.
interface sum_operand_loader_if
   import sum_pkg::*;
#(
   parameter int N = SUM_N,
   parameter int W = SUM_W
) ();

   localparam int CW = cnt_width(N);

   logic            in_valid;
   logic            in_ready;
   logic [W-1:0]    in_data;
   logic            in_last;
   logic [N*W-1:0]  ops_flat;
   logic [CW-1:0]   ops_count;
   logic            ops_valid;
   logic            ops_start;
   logic            sum_done;

   modport master (
      output in_valid, in_data, in_last, sum_done,
      input  in_ready, ops_flat, ops_count, ops_valid, ops_start
   );

   modport slave (
      input  in_valid, in_data, in_last, sum_done,
      output in_ready, ops_flat, ops_count, ops_valid, ops_start
   );

endinterface

// File: rtl/sum_operand_bank.sv
// N x W operand register file. One write port addressed by slot index, plus
// a clear that zeroes every slot at or above a given index in the same
// cycle. A write to a slot that is also being cleared wins, so a frame can
// store its closing operand and zero the unused tail on one edge.
module sum_operand_bank
   import sum_pkg::*;
#(
   parameter int N  = SUM_N,
   parameter int W  = SUM_W,
   parameter int CW = cnt_width(N)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_wr_en,
   input  logic [CW-1:0]   i_wr_idx,
   input  logic [W-1:0]    i_wr_data,
   input  logic            i_clr_en,
   input  logic [CW-1:0]   i_clr_from,
   output logic [N*W-1:0]  o_flat
);

   logic [W-1:0] r_slot [N];

   // Slot storage: tail clear first, then the indexed write overrides it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < N; i++) begin
            r_slot[i] <= '0;
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            if (i_clr_en && (CW'(i) >= i_clr_from)) begin
               r_slot[i] <= '0;
            end
            if (i_wr_en && (CW'(i) == i_wr_idx)) begin
               r_slot[i] <= i_wr_data;
            end
         end
      end
   end

   for (genvar g = 0; g < N; g++) begin : g_flat
      assign o_flat[g*W +: W] = r_slot[g];
   end

endmodule

// File: rtl/sum_operand_loader.sv
// Operand loader in front of the N-operand summer. Collects operands from a
// valid/ready stream into a bank, then presents the bank in parallel with a
// one-cycle start pulse and holds it until the summer reports done.
//
// Build option: LOADER_DBUF_EN adds a second (shadow) bank so the next frame
// can be collected while the summer works on the current one; with the
// macro undefined there is a single bank and no input is taken while busy.
//
// state | meaning
// ------+---------------------------------------------------------------
// FILL  | no frame presented; collecting operands into the fill bank
// BUSY  | frame presented to summer (ops_valid=1), waiting for sum_done;
//       | with LOADER_DBUF_EN the shadow bank keeps collecting
module sum_operand_loader
   import sum_pkg::*;
#(
   parameter int N = SUM_N,
   parameter int W = SUM_W
) (
   input  logic                clk,
   input  logic                rst,
   sum_operand_loader_if.slave bus
);

   localparam int            CW       = cnt_width(N);
   localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

   loader_state_e  r_state;
   loader_state_e  w_state_nxt;
   logic [CW-1:0]  r_idx;
   logic [CW-1:0]  r_count;
   logic [CW-1:0]  w_close_cnt;
   logic           r_start;
   logic           w_start_nxt;
   logic           w_ready;
   logic           w_accept;
   logic           w_close;

   assign w_accept    = bus.in_valid && w_ready;
   // The N-th beat closes the frame whatever in_last says.
   assign w_close     = w_accept && (bus.in_last || (r_idx == LAST_IDX));
   assign w_close_cnt = r_idx + CW'(1);

`ifdef LOADER_DBUF_EN
   logic           r_act;
   logic           r_shadow_full;
   logic [CW-1:0]  r_shadow_cnt;
   logic           w_fill_sel;
   logic           w_shadow_closed;
   logic [N*W-1:0] w_flat0;
   logic [N*W-1:0] w_flat1;

   // In FILL the active bank is the one being filled; in BUSY the other one.
   assign w_fill_sel      = (r_state == FILL) ? r_act : ~r_act;
   assign w_ready         = (r_state == FILL) || !r_shadow_full;
   // A closing beat on the sum_done edge counts as a closed shadow.
   assign w_shadow_closed = r_shadow_full || w_close;

   sum_operand_bank #(.N(N), .W(W), .CW(CW)) u_bank0 (
      .clk        (clk),
      .rst        (rst),
      .i_wr_en    (w_accept && !w_fill_sel),
      .i_wr_idx   (r_idx),
      .i_wr_data  (bus.in_data),
      .i_clr_en   (w_close && !w_fill_sel),
      .i_clr_from (w_close_cnt),
      .o_flat     (w_flat0)
   );

   sum_operand_bank #(.N(N), .W(W), .CW(CW)) u_bank1 (
      .clk        (clk),
      .rst        (rst),
      .i_wr_en    (w_accept && w_fill_sel),
      .i_wr_idx   (r_idx),
      .i_wr_data  (bus.in_data),
      .i_clr_en   (w_close && w_fill_sel),
      .i_clr_from (w_close_cnt),
      .o_flat     (w_flat1)
   );

   assign bus.ops_flat = r_act ? w_flat1 : w_flat0;

   // Bank ownership and shadow bookkeeping. sum_done always hands the
   // shadow over: either it is presented at once (closed) or it becomes the
   // fill bank with its write index intact (incomplete).
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_act         <= 1'b0;
         r_shadow_full <= 1'b0;
         r_shadow_cnt  <= '0;
      end else if (r_state == BUSY) begin
         if (w_close) begin
            r_shadow_full <= 1'b1;
            r_shadow_cnt  <= w_close_cnt;
         end
         if (bus.sum_done) begin
            r_act         <= ~r_act;
            r_shadow_full <= 1'b0;
         end
      end
   end

   // Presented operand count: loaded on a fresh close or on a bank swap.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_count <= '0;
      end else if ((r_state == FILL) && w_close) begin
         r_count <= w_close_cnt;
      end else if ((r_state == BUSY) && bus.sum_done && w_shadow_closed) begin
         r_count <= r_shadow_full ? r_shadow_cnt : w_close_cnt;
      end
   end
`else
   logic [N*W-1:0] w_flat;

   assign w_ready = (r_state == FILL);

   sum_operand_bank #(.N(N), .W(W), .CW(CW)) u_bank (
      .clk        (clk),
      .rst        (rst),
      .i_wr_en    (w_accept),
      .i_wr_idx   (r_idx),
      .i_wr_data  (bus.in_data),
      .i_clr_en   (w_close),
      .i_clr_from (w_close_cnt),
      .o_flat     (w_flat)
   );

   assign bus.ops_flat = w_flat;

   // Presented operand count, captured when the frame closes.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_count <= '0;
      end else if (w_close) begin
         r_count <= w_close_cnt;
      end
   end
`endif

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= FILL;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and start-pulse decode.
   always_comb begin
      w_state_nxt = r_state;
      w_start_nxt = 1'b0;
      case (r_state)
         FILL: begin
            if (w_close) begin
               w_state_nxt = BUSY;
               w_start_nxt = 1'b1;
            end
         end
         BUSY: begin
            if (bus.sum_done) begin
`ifdef LOADER_DBUF_EN
               if (w_shadow_closed) begin
                  w_start_nxt = 1'b1;
               end else begin
                  w_state_nxt = FILL;
               end
`else
               w_state_nxt = FILL;
`endif
            end
         end
         default: w_state_nxt = FILL;
      endcase
   end

   // Write index and registered start pulse; index restarts on every close.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_idx   <= '0;
         r_start <= 1'b0;
      end else begin
         r_start <= w_start_nxt;
         if (w_close) begin
            r_idx <= '0;
         end else if (w_accept) begin
            r_idx <= r_idx + CW'(1);
         end
      end
   end

   assign bus.in_ready  = w_ready;
   assign bus.ops_valid = (r_state == BUSY);
   assign bus.ops_start = r_start;
   assign bus.ops_count = r_count;

endmodule

// File: tb/tb_sum_operand_loader.sv
// Directed bench for sum_operand_loader. The double-buffer scenario is
// compiled in only when LOADER_DBUF_EN is defined for the build.
module tb_sum_operand_loader;
   import sum_pkg::*;

   localparam int N  = SUM_N;
   localparam int W  = SUM_W;
   localparam int CW = cnt_width(N);
`ifdef LOADER_DBUF_EN
   localparam logic DBUF = 1'b1;
`else
   localparam logic DBUF = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   failures = 0;
   int   start_seen = 0;
   int   valid_low = 0;

   always #5 clk = ~clk;

   sum_operand_loader_if #(.N(N), .W(W)) bus ();

   sum_operand_loader #(.N(N), .W(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always @(negedge clk) begin
      if (bus.ops_start === 1'b1) start_seen++;
      if (bus.ops_valid !== 1'b1) valid_low++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic int flat_sum();
      int s = 0;
      logic [N*W-1:0] f = bus.ops_flat;
      for (int i = 0; i < N; i++) s += int'(f[i*W +: W]);
      return s;
   endfunction

   function automatic logic [W-1:0] slot(input int i);
      logic [N*W-1:0] f = bus.ops_flat;
      return f[i*W +: W];
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_beat(input logic [W-1:0] d, input logic l);
      int t = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_last  = l;
      while (bus.in_ready !== 1'b1 && t < 50) begin
         step();
         t++;
      end
      checks++;
      if (t >= 50) begin
         failures++;
         $display("FAIL send_beat_timeout: in_ready=%b after %0d cycles, required 1", bus.in_ready, t);
      end
      step();
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   task automatic release_frame();
      bus.sum_done = 1'b1;
      step();
      bus.sum_done = 1'b0;
      checks++;
      if (bus.ops_valid !== 1'b0) begin
         failures++;
         $display("FAIL release_valid: ops_valid=%b required 0", bus.ops_valid);
      end
      checks++;
      if (bus.in_ready !== 1'b1) begin
         failures++;
         $display("FAIL release_ready: in_ready=%b required 1", bus.in_ready);
      end
   endtask

   task automatic test_reset();
      bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0; bus.sum_done = 1'b0;
      repeat (2) step();
      rst = 1'b1;
      step();
      checks++;
      if (bus.in_ready !== 1'b1 || bus.ops_valid !== 1'b0 || bus.ops_start !== 1'b0) begin
         failures++;
         $display("FAIL reset_ctrl: ready=%b valid=%b start=%b required 1 0 0",
                  bus.in_ready, bus.ops_valid, bus.ops_start);
      end
      checks++;
      if (bus.ops_count !== CW'(0) || bus.ops_flat !== '0) begin
         failures++;
         $display("FAIL reset_data: count=%0d flat=%h required 0 0", bus.ops_count, bus.ops_flat);
      end
      for (int i = 0; i < 7; i++) send_beat(W'(10 + i), 1'b0);
      rst = 1'b0;
      #3;
      rst = 1'b1;
      step();
      checks++;
      if (bus.in_ready !== 1'b1 || bus.ops_valid !== 1'b0 || bus.ops_start !== 1'b0) begin
         failures++;
         $display("FAIL midreset_ctrl: ready=%b valid=%b start=%b required 1 0 0",
                  bus.in_ready, bus.ops_valid, bus.ops_start);
      end
      checks++;
      if (bus.ops_flat !== '0 || bus.ops_count !== CW'(0)) begin
         failures++;
         $display("FAIL midreset_lost: flat=%h count=%0d required 0 0", bus.ops_flat, bus.ops_count);
      end
   endtask

   task automatic test_full_frame();
      int s0 = start_seen;
      for (int v = 1; v <= N; v++) send_beat(W'(v), 1'b0);
      checks++;
      if (bus.ops_start !== 1'b1 || bus.ops_valid !== 1'b1) begin
         failures++;
         $display("FAIL full_start: start=%b valid=%b required 1 1", bus.ops_start, bus.ops_valid);
      end
      checks++;
      if (bus.ops_count !== CW'(20) || flat_sum() != 210) begin
         failures++;
         $display("FAIL full_data: count=%0d sum=%0d required 20 210", bus.ops_count, flat_sum());
      end
      checks++;
      if (slot(0) !== W'(1) || slot(19) !== W'(20)) begin
         failures++;
         $display("FAIL full_order: slot0=%0d slot19=%0d required 1 20", slot(0), slot(19));
      end
      step();
      checks++;
      if (bus.ops_start !== 1'b0 || bus.ops_valid !== 1'b1 || bus.in_ready !== DBUF) begin
         failures++;
         $display("FAIL full_busy: start=%b valid=%b ready=%b required 0 1 %b",
                  bus.ops_start, bus.ops_valid, bus.in_ready, DBUF);
      end
      repeat (3) step();
      checks++;
      if (flat_sum() != 210 || slot(5) !== W'(6) || bus.ops_count !== CW'(20) || start_seen - s0 != 1) begin
         failures++;
         $display("FAIL full_hold: sum=%0d slot5=%0d count=%0d starts=%0d required 210 6 20 1",
                  flat_sum(), slot(5), bus.ops_count, start_seen - s0);
      end
      release_frame();
      bus.sum_done = 1'b1;
      repeat (2) step();
      bus.sum_done = 1'b0;
      checks++;
      if (bus.ops_valid !== 1'b0 || bus.in_ready !== 1'b1 || start_seen - s0 != 1) begin
         failures++;
         $display("FAIL done_ignored: valid=%b ready=%b starts=%0d required 0 1 1",
                  bus.ops_valid, bus.in_ready, start_seen - s0);
      end
   endtask

   task automatic test_short_frame();
      logic [N*W-1:0] f;
      send_beat(W'(31), 1'b0);
      send_beat(W'(31), 1'b0);
      send_beat(W'(31), 1'b1);
      f = bus.ops_flat;
      checks++;
      if (bus.ops_start !== 1'b1 || bus.ops_count !== CW'(3) || flat_sum() != 93) begin
         failures++;
         $display("FAIL short_frame: start=%b count=%0d sum=%0d required 1 3 93",
                  bus.ops_start, bus.ops_count, flat_sum());
      end
      checks++;
      if (f[N*W-1:3*W] !== '0) begin
         failures++;
         $display("FAIL short_tail: tail=%h required 0", f[N*W-1:3*W]);
      end
      release_frame();
   endtask

`ifndef LOADER_DBUF_EN
   task automatic test_backpressure();
      send_beat(W'(5), 1'b0);
      send_beat(W'(6), 1'b1);
      bus.in_valid = 1'b1; bus.in_data = W'(9); bus.in_last = 1'b1;
      repeat (3) step();
      checks++;
      if (bus.in_ready !== 1'b0 || slot(0) !== W'(5) || bus.ops_count !== CW'(2)) begin
         failures++;
         $display("FAIL bp_held: ready=%b slot0=%0d count=%0d required 0 5 2",
                  bus.in_ready, slot(0), bus.ops_count);
      end
      bus.sum_done = 1'b1;
      step();
      bus.sum_done = 1'b0;
      checks++;
      if (bus.ops_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.ops_start !== 1'b0) begin
         failures++;
         $display("FAIL bp_release: valid=%b ready=%b start=%b required 0 1 0",
                  bus.ops_valid, bus.in_ready, bus.ops_start);
      end
      step();
      bus.in_valid = 1'b0; bus.in_last = 1'b0;
      checks++;
      if (bus.ops_start !== 1'b1 || bus.ops_count !== CW'(1) || bus.ops_flat !== (N*W)'(9)) begin
         failures++;
         $display("FAIL bp_landed: start=%b count=%0d flat=%h required 1 1 9",
                  bus.ops_start, bus.ops_count, bus.ops_flat);
      end
      release_frame();
   endtask
`endif

   task automatic test_max_gaps();
      int s0 = start_seen;
      for (int i = 0; i < N; i++) begin
         repeat ($urandom_range(0, 3)) step();
         send_beat(W'(31), 1'b0);
      end
      checks++;
      if (bus.ops_start !== 1'b1 || bus.ops_count !== CW'(20) || flat_sum() != 620) begin
         failures++;
         $display("FAIL max_frame: start=%b count=%0d sum=%0d required 1 20 620",
                  bus.ops_start, bus.ops_count, flat_sum());
      end
      step();
      checks++;
      if (bus.ops_start !== 1'b0 || start_seen - s0 != 1) begin
         failures++;
         $display("FAIL max_pulse: start=%b starts=%0d required 0 1", bus.ops_start, start_seen - s0);
      end
      release_frame();
   endtask

`ifdef LOADER_DBUF_EN
   task automatic test_dbuf();
      int vl0;
      for (int v = 1; v <= N; v++) send_beat(W'(v), 1'b0);
      step();
      vl0 = valid_low;
      send_beat(W'(2), 1'b0);
      send_beat(W'(3), 1'b0);
      send_beat(W'(4), 1'b1);
      checks++;
      if (bus.in_ready !== 1'b0 || bus.ops_count !== CW'(20) || flat_sum() != 210) begin
         failures++;
         $display("FAIL dbuf_shadow: ready=%b count=%0d sum=%0d required 0 20 210",
                  bus.in_ready, bus.ops_count, flat_sum());
      end
      bus.sum_done = 1'b1;
      step();
      bus.sum_done = 1'b0;
      checks++;
      if (bus.ops_valid !== 1'b1 || bus.ops_start !== 1'b1 || bus.ops_count !== CW'(3) || flat_sum() != 9) begin
         failures++;
         $display("FAIL dbuf_swap: valid=%b start=%b count=%0d sum=%0d required 1 1 3 9",
                  bus.ops_valid, bus.ops_start, bus.ops_count, flat_sum());
      end
      step();
      send_beat(W'(7), 1'b0);
      bus.in_valid = 1'b1; bus.in_data = W'(8); bus.in_last = 1'b1; bus.sum_done = 1'b1;
      step();
      bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.sum_done = 1'b0;
      checks++;
      if (bus.ops_valid !== 1'b1 || bus.ops_start !== 1'b1 || bus.ops_count !== CW'(2) || flat_sum() != 15) begin
         failures++;
         $display("FAIL dbuf_same_edge: valid=%b start=%b count=%0d sum=%0d required 1 1 2 15",
                  bus.ops_valid, bus.ops_start, bus.ops_count, flat_sum());
      end
      checks++;
      if (valid_low != vl0) begin
         failures++;
         $display("FAIL dbuf_no_bubble: valid low cycles=%0d required 0", valid_low - vl0);
      end
      send_beat(W'(5), 1'b0);
      bus.sum_done = 1'b1;
      step();
      bus.sum_done = 1'b0;
      checks++;
      if (bus.ops_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         failures++;
         $display("FAIL dbuf_partial: valid=%b ready=%b required 0 1", bus.ops_valid, bus.in_ready);
      end
      send_beat(W'(6), 1'b1);
      checks++;
      if (bus.ops_start !== 1'b1 || bus.ops_count !== CW'(2) || flat_sum() != 11 || slot(0) !== W'(5)) begin
         failures++;
         $display("FAIL dbuf_continue: start=%b count=%0d sum=%0d slot0=%0d required 1 2 11 5",
                  bus.ops_start, bus.ops_count, flat_sum(), slot(0));
      end
      release_frame();
   endtask
`endif

   initial begin
      test_reset();
      test_full_frame();
      test_short_frame();
`ifndef LOADER_DBUF_EN
      test_backpressure();
`endif
      test_max_gaps();
`ifdef LOADER_DBUF_EN
      test_dbuf();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
